// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier control path: FSM state
// encoding and the recoded per-iteration datapath operation.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } booth_state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

endpackage

// File: rtl/booth_recode.sv
// Radix-2 Booth recoder: maps the {q0,qm1} pair onto the operation
// the A register performs in the evaluate step.
module booth_recode
    import booth_pkg::*;
(
    input  logic      q0,
    input  logic      qm1,
    output booth_op_e op
);

    always_comb begin
        op = OP_NOP;
        unique case ({q0, qm1})
            2'b10:   op = OP_SUB;
            2'b01:   op = OP_ADD;
            default: op = OP_NOP;
        endcase
    end

endmodule

// File: rtl/booth_ctrl.sv
// Sequencing FSM for the Booth's multiplier: start handshake, W x
// (evaluate, shift) iterations against an external counter, done handshake.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             q0,
    input  logic             qm1,
    input  logic [CNT_W-1:0] count,
    output logic             load,
    output logic             en_pp,
    output logic             add_en,
    output logic             sub_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    booth_state_e state;
    booth_state_e state_next;
    booth_op_e    op;

    booth_recode u_recode (
        .q0  (q0),
        .qm1 (qm1),
        .op  (op)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode state only (plus the recoded op in EVAL), so the
    // asynchronous clear of state drops every strobe immediately.
    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        busy        = 1'b1;
        load        = 1'b0;
        en_pp       = 1'b0;
        add_en      = 1'b0;
        sub_en      = 1'b0;
        shift_en    = 1'b0;
        done_valid  = 1'b0;

        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                state_next = EVAL;
            end
            EVAL: begin
                add_en     = (op == OP_ADD);
                sub_en     = (op == OP_SUB);
                state_next = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                en_pp    = 1'b1;
                // count is pre-increment; >= also terminates a corrupted count
                if (count >= LAST_ITER) begin
                    state_next = DONE;
                end else begin
                    state_next = EVAL;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: models the iteration counter and a guarded A/Q/Q-1
// datapath, scoreboards products and per-iteration ops.
module tb_booth_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_valid;
    logic             start_ready;
    logic             load, en_pp, add_en, sub_en, shift_en, busy, done_valid;
    logic             done_ready;
    logic [CNT_W-1:0] cnt_r = '0;

    // datapath model; A carries one guard bit so -8 x -8 does not overflow
    logic [4:0] a_r   = '0;
    logic [3:0] q_r   = '0;
    logic [3:0] m_r   = '0;
    logic       qm1_r = 1'b0;
    logic [3:0] mc_in, mp_in;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = -1000;
    int done_cyc = -1000;
    int last_gap = -1;
    int pulses = 0;
    int load_cnt = 0;
    int prev_op = 0;
    int cur_op;
    int base;
    logic dv_prev = 1'b0;
    logic got_it;

    int         op_q[$];
    logic [7:0] prod_q[$];

    booth_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .q0          (q_r[0]),
        .qm1         (qm1_r),
        .count       (cnt_r),
        .load        (load),
        .en_pp       (en_pp),
        .add_en      (add_en),
        .sub_en      (sub_en),
        .shift_en    (shift_en),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (load) begin
            a_r   <= '0;
            q_r   <= mp_in;
            qm1_r <= 1'b0;
            m_r   <= mc_in;
            cnt_r <= '0;
        end else begin
            if (add_en) a_r <= a_r + {m_r[3], m_r};
            if (sub_en) a_r <= a_r - {m_r[3], m_r};
            if (shift_en) {a_r, q_r, qm1_r} <= {a_r[4], a_r, q_r};
            if (en_pp) cnt_r <= cnt_r + 1'b1;
        end
    end

    assign product = {a_r[3:0], q_r};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_prod(input logic [3:0] m, input logic [3:0] q);
        logic signed [7:0] r;
        r = $signed({{4{m[3]}}, m}) * $signed({{4{q[3]}}, q});
        return r;
    endfunction

    task automatic push_expect(input logic [3:0] m, input logic [3:0] q);
        logic b1, b0;
        for (int i = 0; i < WIDTH; i++) begin
            b1 = q[i];
            b0 = (i == 0) ? 1'b0 : q[i-1];
            op_q.push_back((b1 && !b0) ? 2 : (!b1 && b0) ? 1 : 0);
        end
        prod_q.push_back(exp_prod(m, q));
    endtask

    // Monitor: sample mid-cycle, compare strobes/latency/product to scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            dv_prev = 1'b0;
            prev_op = 0;
        end else begin
            cur_op = sub_en ? 2 : (add_en ? 1 : 0);
            if (add_en || sub_en) check("add_sub_exclusive", 32'(add_en & sub_en), 32'd0);
            if (shift_en || en_pp) check("en_pp_with_shift", 32'(en_pp), 32'(shift_en));
            if (shift_en) begin
                pulses++;
                if (op_q.size() == 0) check("op_underflow", 32'd0, 32'd1);
                else check("op_order", 32'(prev_op), 32'(op_q.pop_front()));
            end
            if (load) begin
                pulses = 0;
                load_cnt++;
                last_gap = cyc - done_cyc;
                check("load_latency", 32'(cyc - accept_cyc), 32'd1);
            end
            if (done_valid)
                check("frozen_in_done", 32'({load, add_en, sub_en, shift_en, en_pp}), 32'd0);
            if (done_valid && !dv_prev) begin
                done_cyc = cyc;
                check("done_latency", 32'(cyc - accept_cyc), 32'(2 * WIDTH + 2));
                check("en_pp_pulses", 32'(pulses), 32'(WIDTH));
                if (prod_q.size() == 0) check("prod_underflow", 32'd0, 32'd1);
                else check("product", 32'(product), 32'(prod_q.pop_front()));
            end
            if (start_valid && start_ready) accept_cyc = cyc;
            dv_prev = done_valid;
            prev_op = cur_op;
        end
    end

    task automatic start_mul(input logic [3:0] m, input logic [3:0] q);
        @(posedge clk);
        #2;
        mc_in = m;
        mp_in = q;
        push_expect(m, q);
        start_valid = 1'b1;
        got_it = 1'b0;
        for (int i = 0; i < 40 && !got_it; i++) begin
            @(negedge clk);
            got_it = start_ready;
        end
        if (!got_it) check("start_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        start_valid = 1'b0;
    endtask

    task automatic wait_done();
        got_it = 1'b0;
        for (int i = 0; i < 40 && !got_it; i++) begin
            @(negedge clk);
            got_it = done_valid;
        end
        if (!got_it) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        got_it = 1'b0;
        for (int i = 0; i < 60 && !got_it; i++) begin
            @(negedge clk);
            got_it = !busy;
        end
        if (!got_it) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        start_valid = 1'b0;
        done_ready  = 1'b1;
        mc_in       = '0;
        mp_in       = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("reset_start_ready", 32'(start_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_outputs", 32'({load, en_pp, add_en, sub_en, shift_en, done_valid}), 32'd0);

        // directed and assorted multiplies, done_ready tied high
        start_mul(4'b0011, 4'b1110); wait_idle();
        start_mul(4'b1000, 4'b1000); wait_idle();
        start_mul(4'b0111, 4'b1111); wait_idle();
        start_mul(4'b1011, 4'b0110); wait_idle();
        start_mul(4'b0101, 4'b0101); wait_idle();
        start_mul(4'b0111, 4'b1000); wait_idle();
        for (int k = 0; k < 4; k++) begin
            start_mul(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_idle();
        end

        // consumer stalls in DONE while a start pulse arrives
        done_ready = 1'b0;
        start_mul(4'b0101, 4'b1011);
        wait_done();
        base = load_cnt;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #2 start_valid = (i == 1 || i == 2);
            @(negedge clk);
            check("stall_done_valid", 32'(done_valid), 32'd1);
            check("stall_start_ready", 32'(start_ready), 32'd0);
        end
        @(posedge clk);
        #2;
        start_valid = 1'b0;
        done_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("stall_release_idle", 32'({busy, done_valid, start_ready}), 32'b001);
        check("stall_no_new_load", 32'(load_cnt), 32'(base));

        // asynchronous reset during SHIFT with count==2
        start_mul(4'b0110, 4'b0011);
        got_it = 1'b0;
        for (int i = 0; i < 40 && !got_it; i++) begin
            @(negedge clk);
            got_it = shift_en && (cnt_r == CNT_W'(2));
        end
        if (!got_it) check("shift2_timeout", 32'd0, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_strobes", 32'({load, en_pp, add_en, sub_en, shift_en, done_valid}), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        void'(prod_q.pop_back());
        op_q.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'({start_ready, busy}), 32'b10);

        // back-to-back: start held, done_ready tied high
        done_ready = 1'b1;
        mc_in = 4'b0111;
        mp_in = 4'b1101;
        push_expect(4'b0111, 4'b1101);
        push_expect(4'b0111, 4'b1101);
        base = load_cnt;
        @(posedge clk);
        #2 start_valid = 1'b1;
        got_it = 1'b0;
        for (int i = 0; i < 60 && !got_it; i++) begin
            @(negedge clk);
            got_it = (load_cnt == base + 2);
        end
        if (!got_it) check("b2b_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2 start_valid = 1'b0;
        wait_idle();
        check("b2b_load_gap", 32'(last_gap), 32'd2);
        check("sb_prod_empty", 32'(prod_q.size()), 32'd0);
        check("sb_op_empty", 32'(op_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
